value_glyph_ctrl: RTL

VALUE_GLYPH_CTRL -- requirements
Module: value_glyph_ctrl

---
 rtl/value_glyph_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/value_glyph_ctrl.sv
// Converts CHANNELS binary values to BCD by double dabble and serves 16x16 digit glyph rows.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (least significant digit always shown).
module value_glyph_ctrl #(
  parameter int CHANNELS = 3,
  parameter int VAL_W    = 8,
  parameter int DIGITS   = 3
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               update,
  input  logic [CHANNELS*VAL_W-1:0]                          value_flat,
  output logic                                               busy,
  output logic                                               done,
  input  logic                                               rd_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_ch,
  input  logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]     rd_digit,
  input  logic [3:0]                                         rd_row,
  output logic [15:0]                                        glyph_row,
  output logic                                               glyph_valid
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int BCD_W = DIGITS * 4;

  typedef enum logic [1:0] {IDLE, SHIFT, STORE, DONE} state_t;

  state_t                    state_reg;
  logic [CHANNELS*VAL_W-1:0] latch_reg;
  logic [VAL_W-1:0]          val_reg;
  logic [BCD_W-1:0]          bcd_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [CH_W-1:0]           ch_reg;
  logic [BCD_W-1:0]          bank_reg [CHANNELS];

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [VAL_W-1:0] val_next;
  logic [VAL_W-1:0] next_ch_val;
  logic [CH_W-1:0]  ch_inc;
  logic             last_shift;
  logic             last_ch;

  // Add-3 correction on every BCD nibble before each shift
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_next   = {bcd_adj[BCD_W-2:0], val_reg[VAL_W-1]};
  assign val_next   = val_reg << 1;
  assign ch_inc     = ch_reg + 1'b1;
  assign last_shift = (cnt_reg == CNT_W'(VAL_W - 1));
  assign last_ch    = (ch_reg == CH_W'(CHANNELS - 1));

  always_comb begin
    next_ch_val = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_inc == CH_W'(c)) next_ch_val = latch_reg[c*VAL_W +: VAL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      latch_reg <= '0;
      val_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      for (int c = 0; c < CHANNELS; c++) bank_reg[c] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (update) begin
            latch_reg <= value_flat;
            val_reg   <= value_flat[VAL_W-1:0];
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          val_reg <= val_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_shift) state_reg <= STORE;
        end
        STORE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_reg == CH_W'(c)) bank_reg[c] <= bcd_reg;
          end
          if (last_ch) begin
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
            ch_reg    <= ch_inc;
            val_reg   <= next_ch_val;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        DONE: begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Font ROM: row 0 in the top 16 bits; codes 10..15 are blank
  function automatic logic [15:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [255:0] g;
    case (code)
      4'd0: g = 256'h0000_0FF0_1FF8_381C_381C_383C_387C_38DC_3B1C_3E1C_3C1C_381C_381C_1FF8_0FF0_0000;
      4'd1: g = 256'h0000_01C0_03C0_07C0_0DC0_01C0_01C0_01C0_01C0_01C0_01C0_01C0_01C0_0FF8_0FF8_0000;
      4'd2: g = 256'h0000_0FF0_1FF8_381C_001C_001C_0038_0070_00E0_01C0_0380_0700_0E00_1FFC_1FFC_0000;
      4'd3: g = 256'h0000_0FF0_1FF8_381C_001C_001C_0038_03F0_03F8_001C_001C_001C_381C_1FF8_0FF0_0000;
      4'd4: g = 256'h0000_0070_00F0_01F0_03B0_0730_0E30_1C30_3FFC_3FFC_0030_0030_0030_0030_0030_0000;
      4'd5: g = 256'h0000_3FFC_3FFC_3800_3800_3800_3FF0_3FF8_001C_001C_001C_001C_381C_1FF8_0FF0_0000;
      4'd6: g = 256'h0000_03F0_0FF0_1C00_3800_3800_3FF0_3FF8_381C_381C_381C_381C_381C_1FF8_0FF0_0000;
      4'd7: g = 256'h0000_3FFC_3FFC_001C_001C_0038_0038_0070_0070_00E0_00E0_01C0_01C0_0380_0380_0000;
      4'd8: g = 256'h0000_0FF0_1FF8_381C_381C_381C_1C38_0FF0_1FF8_381C_381C_381C_381C_1FF8_0FF0_0000;
      4'd9: g = 256'h0000_0FF0_1FF8_381C_381C_381C_381C_1FFC_0FFC_001C_001C_001C_0038_0FF0_0FC0_0000;
      default: g = '0;
    endcase
    return g[{4'd15 - row, 4'b0000} +: 16];
  endfunction

  logic [BCD_W-1:0] rd_word;
  logic [3:0]       rd_nib;
  logic             ch_ok;
  logic             dg_ok;
  logic             lz_blank;
  logic [15:0]      row_next;

  always_comb begin
    rd_word  = '0;
    rd_nib   = '0;
    ch_ok    = 1'b0;
    dg_ok    = 1'b0;
    lz_blank = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_word = bank_reg[c];
        ch_ok   = 1'b1;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (rd_digit == DG_W'(d)) begin
        rd_nib = rd_word[(DIGITS-1-d)*4 +: 4];
        dg_ok  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        // Selected nibble and everything above it zero means this is a leading zero
        if (d != DIGITS - 1 && (rd_word >> ((DIGITS-1-d)*4)) == '0) lz_blank = 1'b1;
`endif
      end
    end
    row_next = (ch_ok && dg_ok && !lz_blank) ? font_row(rd_nib, rd_row) : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_row   <= 16'h0000;
      glyph_valid <= 1'b0;
    end else begin
      glyph_valid <= rd_en;
      if (rd_en) glyph_row <= row_next;
    end
  end

endmodule
